// File: rtl/uart_tx_led_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_led_monitor
// Description : Passive 8N1 UART decoder tapping the SoC transmit line; shows
//               the last received byte on active-low LEDs.
//               Optional stop-bit checking: UART_MONITOR_FRAME_CHECK_EN
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_led_monitor #(
    parameter int CLOCK_FREQUENCY = 27000000,
    parameter int UART_BAUD_RATE  = 9600
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_tx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic [5:0] led,
    output logic       frame_error
);

    localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / UART_BAUD_RATE;
    localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
`ifdef UART_MONITOR_FRAME_CHECK_EN
        S_STOP      = 3'd3,
        S_WAIT_IDLE = 3'd4
`else
        S_STOP      = 3'd3
`endif
    } state_t;

    logic [1:0]       sync_q, sync_d;
    logic             line;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
`ifdef UART_MONITOR_FRAME_CHECK_EN
    logic             frame_error_q, frame_error_d;
`endif

    // Idle-high line: synchronizer resets to 1 so reset never fakes a start bit
    assign sync_d = {sync_q[0], uart_tx};
    assign line   = sync_q[1];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_ONE;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
`ifdef UART_MONITOR_FRAME_CHECK_EN
        frame_error_d = frame_error_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = 3'd0;
                if (!line) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = line ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {line, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
`ifdef UART_MONITOR_FRAME_CHECK_EN
                    if (line) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = S_WAIT_IDLE;
                    end
`else
                    rx_data_d  = shift_q;
                    rx_valid_d = 1'b1;
                    state_d    = S_IDLE;
`endif
                end
            end
`ifdef UART_MONITOR_FRAME_CHECK_EN
            // A held-low line (break) must return high before a new start
            S_WAIT_IDLE: begin
                cnt_d = '0;
                if (line) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q     <= 2'b11;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

`ifdef UART_MONITOR_FRAME_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_error_q <= 1'b0;
        end else begin
            frame_error_q <= frame_error_d;
        end
    end

    assign frame_error = frame_error_q;
`else
    assign frame_error = 1'b0;
`endif

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign led      = ~rx_data_q[5:0];

endmodule

`default_nettype wire
